// File: rtl/net_pkg.sv
// Frame layout and scheduler state encoding shared by the Ethernet game-state transmit path.
package net_pkg;

  localparam int FRAME_W  = 44;
  localparam int X_MSB    = 43;
  localparam int X_LSB    = 33;
  localparam int Y_MSB    = 31;
  localparam int Y_LSB    = 21;
  localparam int DIR_MSB  = 19;
  localparam int DIR_LSB  = 11;
  localparam int SEQ_MSB  = 10;
  localparam int SEQ_LSB  = 8;
  localparam int GAME_MSB = 7;
  localparam int GAME_LSB = 5;
  localparam int RST_BIT  = 3;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} tx_sched_state_t;

  // Unlisted bit positions in the frame are reserved and always zero.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [10:0] x,
    input logic [10:0] y,
    input logic [8:0]  dir,
    input logic [2:0]  seq,
    input logic [2:0]  game,
    input logic        rst_flag
  );
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[X_MSB:X_LSB]       = x;
    f[Y_MSB:Y_LSB]       = y;
    f[DIR_MSB:DIR_LSB]   = dir;
    f[SEQ_MSB:SEQ_LSB]   = seq;
    f[GAME_MSB:GAME_LSB] = game;
    f[RST_BIT]           = rst_flag;
    return f;
  endfunction

endpackage

// File: rtl/net_tx_scheduler_period_ticker.sv
// Free-running 0..PERIOD-1 counter; wrap_o is high for the single cycle before it returns to 0.
module period_ticker #(
  parameter int PERIOD = 833_333
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic wrap_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = (cnt_q == CW'(PERIOD - 1));
    cnt_d  = wrap_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/net_tx_scheduler.sv
// Game-state frame scheduler: periodic, game-change and reset-broadcast frames with busy/ack handshake.
// Statistics counters are built only when NET_TX_SCHED_STATS_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a pending source while the transmitter is free
// WAIT_ACK  | frame launched, waiting for tx_busy to rise (bounded by ACK_TIMEOUT)
// WAIT_DONE | frame accepted, waiting for tx_busy to fall
module net_tx_scheduler
  import net_pkg::*;
#(
  parameter int PERIOD_CYCLES = 833_333,
  parameter int EVENT_REPEAT  = 3,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        player_x,
  input  logic [10:0]        player_y,
  input  logic [8:0]         player_dir,
  input  logic [2:0]         game_stat,
  input  logic               local_reset_req,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [FRAME_W-1:0] tx_data,
  output logic [15:0]        sent_count,
  output logic [15:0]        overrun_count,
  output logic [7:0]         timeout_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  tx_sched_state_t    state_q, state_d;
  logic               tx_start_q, tx_start_d;
  logic [FRAME_W-1:0] tx_data_q, tx_data_d;
  logic [2:0]         seq_q, seq_d;
  logic [2:0]         last_game_q, last_game_d;
  logic               tick_pend_q, tick_pend_d;
  logic [2:0]         reset_rem_q, reset_rem_d;
  logic [TW-1:0]      tmr_q, tmr_d;

  logic wrap;
  logic game_pend;
  logic any_pend;
  logic ack;

  period_ticker #(.PERIOD(PERIOD_CYCLES)) u_ticker (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .wrap_o (wrap)
  );

  // Busy seen during the launch cycle itself belongs to someone else's frame.
  always_comb begin
    game_pend = (game_stat != last_game_q);
    any_pend  = tick_pend_q | game_pend | (reset_rem_q != '0);
    ack       = (state_q == WAIT_ACK) && tx_busy && !tx_start_q;
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tmr_d      = tmr_q;
    case (state_q)
      IDLE: begin
        if (any_pend && !tx_busy) begin
          tx_data_d  = pack_frame(player_x, player_y, player_dir, seq_q, game_stat,
                                  reset_rem_q != '0);
          tx_start_d = 1'b1;
          tmr_d      = TW'(ACK_TIMEOUT - 1);
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack)                state_d = WAIT_DONE;
        else if (tmr_q == '0)   state_d = IDLE;
        else                    tmr_d   = tmr_q - TW'(1);
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new tick or reset request landing on the ack cycle takes precedence over the clear.
  always_comb begin
    tick_pend_d = tick_pend_q;
    if (wrap)     tick_pend_d = 1'b1;
    else if (ack) tick_pend_d = 1'b0;

    reset_rem_d = reset_rem_q;
    if (local_reset_req)
      reset_rem_d = 3'(EVENT_REPEAT);
    else if (ack && tx_data_q[RST_BIT] && (reset_rem_q != '0))
      reset_rem_d = reset_rem_q - 3'd1;

    last_game_d = ack ? tx_data_q[GAME_MSB:GAME_LSB] : last_game_q;
    seq_d       = ack ? seq_q + 3'd1 : seq_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      tmr_q       <= '0;
      seq_q       <= '0;
      last_game_q <= '0;
      tick_pend_q <= 1'b0;
      reset_rem_q <= '0;
    end else begin
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      tmr_q       <= tmr_d;
      seq_q       <= seq_d;
      last_game_q <= last_game_d;
      tick_pend_q <= tick_pend_d;
      reset_rem_q <= reset_rem_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

`ifdef NET_TX_SCHED_STATS_EN
  logic        timeout;
  logic [15:0] sent_q, sent_d;
  logic [15:0] overrun_q, overrun_d;
  logic [7:0]  timeout_q, timeout_d;

  always_comb begin
    timeout   = (state_q == WAIT_ACK) && !ack && (tmr_q == '0);
    sent_d    = ack ? sent_q + 16'd1 : sent_q;
    overrun_d = (wrap && tick_pend_q) ? overrun_q + 16'd1 : overrun_q;
    timeout_d = (timeout && (timeout_q != 8'hff)) ? timeout_q + 8'd1 : timeout_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sent_q    <= '0;
      overrun_q <= '0;
      timeout_q <= '0;
    end else begin
      sent_q    <= sent_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign sent_count    = sent_q;
  assign overrun_count = overrun_q;
  assign timeout_count = timeout_q;
`else
  assign sent_count    = '0;
  assign overrun_count = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_net_tx_scheduler.sv
// Directed bench for net_tx_scheduler: expected frames are queued with their launch cycle
// and popped by a monitor whenever tx_start is seen.
module tb_net_tx_scheduler;

  logic        clk_in;
  logic        rst_in;
  logic [10:0] player_x;
  logic [10:0] player_y;
  logic [8:0]  player_dir;
  logic [2:0]  game_stat;
  logic        local_reset_req;
  logic        tx_busy;
  logic        tx_start;
  logic [43:0] tx_data;
  logic [15:0] sent_count;
  logic [15:0] overrun_count;
  logic [7:0]  timeout_count;

  logic        xm_busy;
  logic        xm_mode;
  logic        foreign_busy;
  int          xm_cnt;
  int          cyc;
  int          n_total;
  int          n_pass;
  int          n_fail;
  int          unstable;

  typedef struct {
    int          cyc;
    logic [43:0] frame;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [43:0] mon_prev_data;
  logic        mon_prev_start;

  assign tx_busy = xm_busy | foreign_busy;

  net_tx_scheduler #(
    .PERIOD_CYCLES (100),
    .EVENT_REPEAT  (3),
    .ACK_TIMEOUT   (16)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .player_x        (player_x),
    .player_y        (player_y),
    .player_dir      (player_dir),
    .game_stat       (game_stat),
    .local_reset_req (local_reset_req),
    .tx_busy         (tx_busy),
    .tx_start        (tx_start),
    .tx_data         (tx_data),
    .sent_count      (sent_count),
    .overrun_count   (overrun_count),
    .timeout_count   (timeout_count)
  );

  initial begin
    clk_in = 1'b0;
    forever #10 clk_in = ~clk_in;
  end

  // Cycle index: number of rising edges since the last reset release.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_in);
      if (rst_in) cyc = 0;
      else        cyc++;
    end
  end

  function automatic int stat(input int v);
`ifdef NET_TX_SCHED_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic logic [43:0] mk(input logic [2:0] seq, input logic [2:0] g, input logic f);
    return {player_x, 1'b0, player_y, 1'b0, player_dir, seq, g, 1'b0, f, 3'b000};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic [2:0] seq, input logic [2:0] g, input logic f);
    exp_t e;
    e.cyc   = c;
    e.frame = mk(seq, g, f);
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  // Transmitter model: busy rises 2 cycles after tx_start and stays high for 20 cycles.
  initial begin
    xm_busy = 1'b0;
    xm_cnt  = -1;
    forever begin
      @(negedge clk_in);
      if (xm_cnt >= 0) xm_cnt++;
      if (tx_start && xm_mode && xm_cnt < 0) xm_cnt = 0;
      xm_busy = (xm_cnt >= 2) && (xm_cnt < 22);
      if (xm_cnt >= 22) xm_cnt = -1;
    end
  end

  initial begin
    mon_prev_data  = '0;
    mon_prev_start = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        mon_prev_data  = '0;
        mon_prev_start = 1'b0;
      end else begin
        if (tx_start) begin
          check("start_one_cycle", 64'(mon_prev_start), 64'(0));
          check("launch_expected", 64'(sb_q.size() != 0), 64'(1));
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("launch_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("frame", 64'(tx_data), 64'(mon_e.frame));
          end
          mon_prev_data = tx_data;
        end else if (tx_data !== mon_prev_data) begin
          unstable++;
        end
        mon_prev_start = tx_start;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; unstable = 0;
    rst_in = 1'b1; local_reset_req = 1'b0; foreign_busy = 1'b0; xm_mode = 1'b1;
    player_x = 11'h123; player_y = 11'h456; player_dir = 9'h1a5; game_stat = 3'd0;
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_tx_start", 64'(tx_start), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_sent", 64'(sent_count), 64'(0));
    check("rst_overrun", 64'(overrun_count), 64'(0));
    check("rst_timeout", 64'(timeout_count), 64'(0));
    @(negedge clk_in);
    rst_in = 1'b0;

    // periodic frames
    push(101, 3'd0, 3'd0, 1'b0);
    push(201, 3'd1, 3'd0, 1'b0);
    push(301, 3'd2, 3'd0, 1'b0);
    wait_cyc(330);
    check("periodic_sent", 64'(sent_count), 64'(stat(3)));
    check("periodic_sb_empty", 64'(sb_q.size()), 64'(0));

    // reset broadcast, then a reload during the second flagged frame
    local_reset_req = 1'b1;
    push(332, 3'd3, 3'd0, 1'b1);
    push(356, 3'd4, 3'd0, 1'b1);
    @(negedge clk_in);
    local_reset_req = 1'b0;
    wait_cyc(360);
    local_reset_req = 1'b1;
    push(380, 3'd5, 3'd0, 1'b1);
    push(404, 3'd6, 3'd0, 1'b1);
    push(428, 3'd7, 3'd0, 1'b1);
    push(501, 3'd0, 3'd0, 1'b0);
    @(negedge clk_in);
    local_reset_req = 1'b0;
    wait_cyc(530);
    check("reset_sent", 64'(sent_count), 64'(stat(9)));
    check("reset_sb_empty", 64'(sb_q.size()), 64'(0));

    // game status change mid-period
    wait_cyc(540);
    game_stat = 3'd2;
    push(541, 3'd1, 3'd2, 1'b0);
    push(601, 3'd2, 3'd2, 1'b0);

    // foreign busy across several ticks: one coalesced launch afterwards
    wait_cyc(690);
    check("game_sb_empty", 64'(sb_q.size()), 64'(0));
    check("game_sent", 64'(sent_count), 64'(stat(11)));
    foreign_busy = 1'b1;
    player_y = 11'h7ff;
    push(941, 3'd3, 3'd2, 1'b0);
    wait_cyc(940);
    foreign_busy = 1'b0;
    wait_cyc(960);
    check("overrun_count", 64'(overrun_count), 64'(stat(2)));
    check("overrun_sb_empty", 64'(sb_q.size()), 64'(0));
    push(1001, 3'd4, 3'd2, 1'b0);

    // transmitter silent: relaunch every 17 cycles with unchanged seq
    wait_cyc(1030);
    check("pre_timeout_sent", 64'(sent_count), 64'(stat(13)));
    xm_mode = 1'b0;
    push(1101, 3'd5, 3'd2, 1'b0);
    wait_cyc(1110);
    player_x = 11'h555;
    push(1118, 3'd5, 3'd2, 1'b0);
    push(1135, 3'd5, 3'd2, 1'b0);
    push(1152, 3'd5, 3'd2, 1'b0);
    wait_cyc(1140);
    check("timeout_mid", 64'(timeout_count), 64'(stat(2)));
    xm_mode = 1'b1;
    push(1201, 3'd6, 3'd2, 1'b0);
    wait_cyc(1180);
    check("timeout_final", 64'(timeout_count), 64'(stat(3)));
    check("timeout_sent", 64'(sent_count), 64'(stat(14)));
    check("timeout_overrun", 64'(overrun_count), 64'(stat(2)));

    // asynchronous reset while in WAIT_DONE
    wait_cyc(1210);
    check("pre_rst_sent", 64'(sent_count), 64'(stat(15)));
    rst_in = 1'b1;
    game_stat = 3'd0;
    #1;
    check("arst_tx_start", 64'(tx_start), 64'(0));
    check("arst_tx_data", 64'(tx_data), 64'(0));
    check("arst_sent", 64'(sent_count), 64'(0));
    check("arst_overrun", 64'(overrun_count), 64'(0));
    check("arst_timeout", 64'(timeout_count), 64'(0));
    check("arst_sb_empty", 64'(sb_q.size()), 64'(0));
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    push(101, 3'd0, 3'd0, 1'b0);
    push(201, 3'd1, 3'd0, 1'b0);
    wait_cyc(230);
    check("post_rst_sent", 64'(sent_count), 64'(stat(2)));
    check("post_rst_overrun", 64'(overrun_count), 64'(0));
    check("post_rst_sb_empty", 64'(sb_q.size()), 64'(0));
    check("tx_data_stable", 64'(unstable), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
